bdc_line_scheduler: RTL

- Sequences the barrel-distortion correction datapath for one frame at a time.
- Tracks which input lines occupy the circular line buffer.
- Throttles the input side so a line slot is never overwritten while an output row still needs it.
- Grants output rows to the remap engine only once every source line that row can touch (within ±MARGIN lines) has been written.

---
 rtl/bdc_line_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bdc_line_scheduler.sv
// bdc_line_scheduler
//   Frame sequencer for the barrel-distortion correction datapath. Tracks
//   which input lines sit in the circular line buffer, throttles the writer
//   so a slot is never reused while a pending output row may still read it,
//   and grants output rows only once every source line within +/-MARGIN
//   of the row has been written.
//
//   Optional build macro: BDC_SCHED_STATS_EN adds the stall_cycles counter.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   in_sof         pulse: first pixel of a frame (also a mid-frame resync)
//   in_line_done   pulse: last pixel of an input line accepted
//   in_line_ok     a free slot exists, the writer may start the next line
//   wr_slot        slot for the line currently being written
//   row_valid      output row grant (registered)
//   row_ready      remap engine accepts the grant
//   row_y          row index being granted
//   row_top_slot   slot holding line max(0, row_y-MARGIN)
//   row_done       pulse: remap engine finished the granted row
//   frame_done     one-cycle pulse after the last row_done of the frame
//   err_overrun    sticky: a line arrived with no free slot / outside a frame
//   stall_cycles   (BDC_SCHED_STATS_EN) cycles the engine starved for lines
module bdc_line_scheduler #(
  parameter int HEIGHT       = 1080,
  parameter int BUFFER_LINES = 16,
  parameter int MARGIN       = 7,
  parameter int CNT_W        = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_sof,
  input  logic                            in_line_done,
  output logic                            in_line_ok,
  output logic [$clog2(BUFFER_LINES)-1:0] wr_slot,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [CNT_W-1:0]                row_y,
  output logic [$clog2(BUFFER_LINES)-1:0] row_top_slot,
  input  logic                            row_done,
  output logic                            frame_done,
`ifdef BDC_SCHED_STATS_EN
  output logic [31:0]                     stall_cycles,
`endif
  output logic                            err_overrun
);

  localparam int SLOT_W = $clog2(BUFFER_LINES);
  localparam logic [CNT_W-1:0] H  = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0] M  = CNT_W'(MARGIN);
  localparam logic [CNT_W-1:0] BL = CNT_W'(BUFFER_LINES);
  localparam logic [CNT_W-1:0] FILL_NEED = (MARGIN + 1 < HEIGHT) ? CNT_W'(MARGIN + 1) : H;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] l_cnt, i_cnt, d_cnt, d_nxt;
  logic [CNT_W-1:0] o_line, top_line, row_need;
  logic [CNT_W:0]   i_sum;
  logic             issue_ok, line_acc, row_acc, done_acc, fd_nxt;

  // Oldest line any not-yet-finished row can still read.
  assign o_line   = (d_cnt > M) ? d_cnt - M : '0;
  assign top_line = (i_cnt > M) ? i_cnt - M : '0;

  // Row I needs lines up to I+MARGIN, clipped at the frame bottom.
  assign i_sum    = {1'b0, i_cnt} + (CNT_W+1)'(MARGIN + 1);
  assign row_need = (i_sum > {1'b0, H}) ? H : i_sum[CNT_W-1:0];

  // Decoded from registers only; no input-to-output path.
  assign in_line_ok = (state == FILL || state == RUN) && (l_cnt < H) &&
                      ((l_cnt - o_line) < BL);

  // At most one row outstanding, so a grant can only go out when I==D.
  assign issue_ok = (state != IDLE) && (i_cnt == d_cnt) && (i_cnt < H) &&
                    (l_cnt >= row_need);

  assign line_acc = in_line_done && in_line_ok;
  assign row_acc  = row_valid && row_ready;
  assign done_acc = row_done && (i_cnt != d_cnt);
  assign d_nxt    = d_cnt + CNT_W'(done_acc);

  assign wr_slot      = l_cnt[SLOT_W-1:0];
  assign row_y        = i_cnt;
  assign row_top_slot = top_line[SLOT_W-1:0];

  always_comb begin
    state_nxt = state;
    fd_nxt    = 1'b0;
    if (in_sof) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FILL:  if (l_cnt >= FILL_NEED) state_nxt = RUN;
        RUN:   if (l_cnt == H) state_nxt = DRAIN;
        DRAIN: if (d_nxt == H) begin
                 // Pulse lands in the cycle right after the last row_done.
                 state_nxt = IDLE;
                 fd_nxt    = 1'b1;
               end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      l_cnt       <= '0;
      i_cnt       <= '0;
      d_cnt       <= '0;
      row_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= fd_nxt;
      // Rejected lines are flagged; a resync leaves the flag alone.
      if (in_line_done && !in_line_ok) err_overrun <= 1'b1;
      if (in_sof) begin
        // Start of frame or resync: drop any outstanding grant.
        l_cnt     <= '0;
        i_cnt     <= '0;
        d_cnt     <= '0;
        row_valid <= 1'b0;
      end else begin
        if (line_acc) l_cnt <= l_cnt + 1'b1;
        if (row_acc)  i_cnt <= i_cnt + 1'b1;
        d_cnt     <= d_nxt;
        row_valid <= issue_ok && !row_acc;
      end
    end
  end

`ifdef BDC_SCHED_STATS_EN
  logic stall;
  assign stall = (state == RUN || state == DRAIN) && (i_cnt == d_cnt) &&
                 (i_cnt < H) && !issue_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cycles <= '0;
    else if (in_sof)                     stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
